// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and load/store data.
// Data has fixed priority, fetch has a starvation guard, and hung accesses are aborted by timeout.
module mem_port_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int MAX_DATA_BURST = 3,
    parameter int TIMEOUT        = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam int SW = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM_I,
        MEM_D
    } state_t;

    state_t state, state_nxt;

    logic [SW-1:0]     streak, streak_nxt;
    logic [TW-1:0]     tmo_cnt, tmo_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt, busy_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;

    logic i_ok, d_ok, grant_d, grant_i, tmo_hit;

    // A port whose ack is high this cycle still shows its old request; ignore it.
    assign i_ok    = if_req & ~if_ack;
    assign d_ok    = d_req & ~d_ack;
    assign grant_d = d_ok & (~i_ok | (streak < STREAK_MAX));
    assign grant_i = ~grant_d & i_ok;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            tmo_cnt   <= tmo_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_ack    <= if_ack_nxt;
            if_err    <= if_err_nxt;
            if_rdata  <= if_rdata_nxt;
            d_ack     <= d_ack_nxt;
            d_err     <= d_err_nxt;
            d_rdata   <= d_rdata_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d)      state_nxt = MEM_D;
                else if (grant_i) state_nxt = MEM_I;
            end
            MEM_I, MEM_D: begin
                if (mem_ack || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        streak_nxt    = streak;
        tmo_nxt       = tmo_cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_ack_nxt    = 1'b0;
        if_err_nxt    = 1'b0;
        if_rdata_nxt  = if_rdata;
        d_ack_nxt     = 1'b0;
        d_err_nxt     = 1'b0;
        d_rdata_nxt   = d_rdata;
        busy_nxt      = (state_nxt != IDLE);
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    tmo_nxt       = '0;
                    // grant_d with a live fetch implies streak < MAX, so this saturates.
                    if (i_ok) streak_nxt = streak + 1'b1;
                end else if (grant_i) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    tmo_nxt       = '0;
                    streak_nxt    = '0;
                end
            end
            MEM_I: begin
                if (mem_ack) begin
                    mem_req_nxt  = 1'b0;
                    if_ack_nxt   = 1'b1;
                    if_rdata_nxt = mem_rdata;
                end else if (tmo_hit) begin
                    mem_req_nxt  = 1'b0;
                    if_ack_nxt   = 1'b1;
                    if_err_nxt   = 1'b1;
                    if_rdata_nxt = '0;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            MEM_D: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    d_ack_nxt   = 1'b1;
                    d_rdata_nxt = mem_we ? '0 : mem_rdata;
                end else if (tmo_hit) begin
                    mem_req_nxt = 1'b0;
                    d_ack_nxt   = 1'b1;
                    d_err_nxt   = 1'b1;
                    d_rdata_nxt = '0;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
